// File: rtl/priority_encoder_4x2_if.sv
// priority_encoder_4x2_if: request capture inputs and valid/ready index channel with ack strobe
interface priority_encoder_4x2_if;
  logic       en_n;
  logic [3:0] req_n;
  logic       ready;
  logic       valid;
  logic [1:0] code;
  logic [3:0] ack_n;
  logic       any;
  modport master (output en_n, req_n, ready, input valid, code, ack_n, any);
  modport slave (input en_n, req_n, ready, output valid, code, ack_n, any);
endinterface

// File: rtl/priority_encoder_4x2.sv
// priority_encoder_4x2: sticky active-low request capture, one 2-bit index per valid/ready handshake
module priority_encoder_4x2 #(
  parameter bit RR_EN = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  priority_encoder_4x2_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0] state_q, state_d;
  logic [3:0] pend_q, pend_d, ack_q, ack_d, clr, cand;
  logic [1:0] code_q, code_d, ptr_q, ptr_d, idx, sel;
  logic       hs, load;
  // selection looks only at what survives this cycle's clear; new requests wait one edge in pend
  always_comb begin
    hs = state_q == HOLD && bus.ready;
    clr = hs ? 4'b0001 << code_q : 4'b0000;
    cand = pend_q & ~clr;
    pend_d = cand | (bus.en_n ? 4'b0000 : ~bus.req_n);
    ptr_d = hs ? code_q + 2'd1 : ptr_q;
    idx = 2'd0;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = RR_EN ? ptr_d + 2'(i) : 2'(3 - i);
      sel = cand[idx] ? idx : sel;
    end
    load = (state_q == IDLE || bus.ready) && |cand;
    code_d = load ? sel : code_q;
    state_d = (state_q == HOLD && !bus.ready) || load ? HOLD : IDLE;
    ack_d = hs ? ~clr : 4'hf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= 4'h0;
      ack_q <= 4'hf;
      code_q <= 2'd0;
      ptr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ack_q <= ack_d;
      code_q <= code_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.valid = state_q == HOLD;
  assign bus.code = code_q;
  assign bus.ack_n = ack_q;
  assign bus.any = |pend_q;
endmodule
